lcd_12864b_seq: RTL and testbench
=================================

// Module: lcd_12864b_seq
// PURPOSE
//  Sequencer in front of the LCD 12864B driver queue. After reset it issues the power-up
//  init command list, then keeps a 4x16 character shadow buffer and redraws dirty rows.
//  Host logic writes characters at (row,col) any cycle; the block schedules the DDRAM
//  address and data bytes into the queue and honours its full flag.
// PARAMETERS
//  PWRUP_CYC  2_000_000  idle cycles after reset before the first command (40 ms @ 50 MHz)
//  CLR_CYC    150_000    wait after enqueuing 0x01 (clear); must cover queue drain + 1.6 ms
// PORTS
//  clk        in   1  system clock, all logic on posedge
//  rst_n      in   1  asynchronous, active-low reset
//  host_we    in   1  shadow write strobe, accepted every cycle
//  host_row   in   2  row 0..3
//  host_col   in   4  column 0..15
//  host_char  in   8  character code
//  refresh    in   1  pulse: mark all 4 rows dirty
//  q_full     in   1  driver queue full
//  q_data     out  8  byte to queue
//  q_cmd      out  1  0 = instruction (RS=0), 1 = display data (RS=1)
//  q_wr       out  1  enqueue strobe, one byte per high cycle
//  init_done  out  1  high once init list complete, stays high until reset
//  busy       out  1  high in every state except IDLE
// BEHAVIOUR
//  Reset: state=PWRUP, q_wr=0, q_data=0x00, q_cmd=0, init_done=0, busy=1, dirty=4'b1111,
//   rr=0, timer=0, all 64 shadow bytes=0x20 (space). Reset mid-operation abandons any row.
//  Emit rule: internal emit_valid with registered q_data/q_cmd; q_wr = emit_valid & ~q_full
//   (combinational gate). A byte counts as sent only in a cycle with q_wr=1; otherwise it is
//   held unchanged. Never drop, never duplicate.
//  FSM:
//   PWRUP   : count PWRUP_CYC cycles -> INIT, idx=0.
//   INIT    : emit instr list {0x30,0x30,0x0C,0x01,0x06}, idx++ per sent byte; after 0x01
//             is sent -> CLR_WAIT; after 0x06 is sent -> IDLE, init_done=1.
//   CLR_WAIT: count CLR_CYC cycles, emit_valid=0 -> INIT (idx=4).
//   IDLE    : if dirty!=0 pick first dirty row scanning rr,rr+1,.. mod 4; clear its dirty
//             bit, latch row, col=0 -> ADDR. Else stay.
//   ADDR    : emit instr row base {0x80,0x90,0x88,0x98}[row]; on send -> DATA.
//   DATA    : emit shadow[row][col] as data; on send col++; after col 15 sent ->
//             rr=row+1 mod 4, -> IDLE.
//  Host writes: shadow[host_row][host_col]<=host_char and dirty[host_row]<=1 same cycle,
//   in every state including PWRUP/INIT. Set beats clear: write to a row in the IDLE cycle
//   that selects it leaves dirty set. Write to the row being streamed re-marks it dirty so
//   it is redrawn in full; bytes already sent are not patched.
//  refresh: dirty<=4'b1111; combined with host_we, OR semantics.
//  DATA reads shadow at the latched col at the time the byte is loaded, so a write to a not
//   yet sent column appears in the current pass.
//  Counters: 5-bit... timer width $clog2(max(PWRUP_CYC,CLR_CYC)+1); col 4 bits, wrap
//   at 15 ends the row; rr 2 bits, natural wrap.
//  Latency: IDLE->first q_wr of ADDR = 1 cycle when q_full=0; a full row = 17 bytes,
//   17 cycles minimum with q_full=0.
//  q_full held high indefinitely: FSM freezes on current byte, timers in PWRUP/CLR_WAIT
//   still run.
// TESTING
//  T1 reset, q_full=0, PWRUP_CYC=10, CLR_CYC=5 -> q_wr bytes 30,30,0C,01 (q_cmd=0), 5 idle
//     cycles, 06; init_done=1; then rows 0..3: 80,16x20 / 90,.. / 88,.. / 98,.. ; busy=0.
//  T2 after idle, write 'A'(0x41) at (2,3) -> sequence 88, 20,20,20,41, 12x20; only row 2.
//  T3 q_full toggles 1,0 every other cycle during row 0 -> exactly 17 bytes, in order, no
//     repeats, q_wr never high while q_full=1.
//  T4 rows 3 and 1 dirty with rr=2 -> row 3 drawn before row 1; then rr=0.
//  T5 while row 1 streams col 8, write 0x5A at (1,2) -> row 1 completes, then full redraw of
//     row 1 with 0x5A at col 2.
//  T6 assert rst_n=0 mid-DATA -> outputs to reset values next edge-free; init list restarts.

Source files
------------

// File: rtl/lcd_12864b_seq.sv
// LCD 12864B command sequencer: power-up init list, then a 4x16 character shadow
// buffer whose dirty rows are redrawn into the driver queue one byte per accepted cycle.
module lcd_12864b_seq #(
  parameter int PWRUP_CYC = 2_000_000,
  parameter int CLR_CYC   = 150_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       host_we,
  input  logic [1:0] host_row,
  input  logic [3:0] host_col,
  input  logic [7:0] host_char,
  input  logic       refresh,
  input  logic       q_full,
  output logic [7:0] q_data,
  output logic       q_cmd,
  output logic       q_wr,
  output logic       init_done,
  output logic       busy
);

  localparam int TMAX = (PWRUP_CYC > CLR_CYC) ? PWRUP_CYC : CLR_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] PWRUP_LAST = TW'(PWRUP_CYC - 1);
  localparam logic [TW-1:0] CLR_LAST   = TW'(CLR_CYC - 1);

  typedef enum logic [2:0] {
    PWRUP,
    INIT,
    CLR_WAIT,
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t          state, state_n;
  logic [TW-1:0]   timer, timer_n;
  logic [2:0]      idx, idx_n;
  logic [1:0]      row, row_n;
  logic [3:0]      col, col_n;
  logic [3:0]      col_inc;
  logic [1:0]      rr, rr_n;
  logic [3:0]      dirty, dirty_clr, dirty_set;
  logic            emit_valid, emit_valid_n;
  logic [7:0]      q_data_n;
  logic            q_cmd_n;
  logic            init_done_n;
  logic            sent;
  logic            pick_found;
  logic [1:0]      pick_row;
  logic [1:0]      cand;
  logic [7:0]      shadow [4][16];

  function automatic logic [7:0] init_byte(input logic [2:0] i);
    case (i)
      3'd0:    init_byte = 8'h30;
      3'd1:    init_byte = 8'h30;
      3'd2:    init_byte = 8'h0C;
      3'd3:    init_byte = 8'h01;
      3'd4:    init_byte = 8'h06;
      default: init_byte = 8'h00;
    endcase
  endfunction

  // DDRAM start addresses: the 12864B interleaves rows 2/3 after rows 0/1.
  function automatic logic [7:0] row_base(input logic [1:0] r);
    case (r)
      2'd0:    row_base = 8'h80;
      2'd1:    row_base = 8'h90;
      2'd2:    row_base = 8'h88;
      default: row_base = 8'h98;
    endcase
  endfunction

  assign sent    = emit_valid & ~q_full;
  assign q_wr    = sent;
  assign busy    = (state != IDLE);
  assign col_inc = col + 4'd1;

  // Round-robin pick; the descending loop lets the smallest offset from rr win.
  always_comb begin
    pick_found = 1'b0;
    pick_row   = rr;
    cand       = rr;
    for (int i = 3; i >= 0; i--) begin
      cand = rr + 2'(i);
      if (dirty[cand]) begin
        pick_found = 1'b1;
        pick_row   = cand;
      end
    end
  end

  always_comb begin
    state_n      = state;
    timer_n      = timer;
    idx_n        = idx;
    row_n        = row;
    col_n        = col;
    rr_n         = rr;
    emit_valid_n = emit_valid;
    q_data_n     = q_data;
    q_cmd_n      = q_cmd;
    init_done_n  = init_done;
    dirty_clr    = 4'b0000;

    case (state)
      PWRUP: begin
        emit_valid_n = 1'b0;
        if (timer == PWRUP_LAST) begin
          state_n      = INIT;
          timer_n      = '0;
          idx_n        = 3'd0;
          emit_valid_n = 1'b1;
          q_data_n     = init_byte(3'd0);
          q_cmd_n      = 1'b0;
        end else begin
          timer_n = timer + TW'(1);
        end
      end

      INIT: begin
        if (sent) begin
          if (idx == 3'd3) begin
            state_n      = CLR_WAIT;
            timer_n      = '0;
            emit_valid_n = 1'b0;
          end else if (idx == 3'd4) begin
            state_n      = IDLE;
            emit_valid_n = 1'b0;
            init_done_n  = 1'b1;
          end else begin
            idx_n    = idx + 3'd1;
            q_data_n = init_byte(idx + 3'd1);
          end
        end
      end

      CLR_WAIT: begin
        emit_valid_n = 1'b0;
        if (timer == CLR_LAST) begin
          state_n      = INIT;
          timer_n      = '0;
          idx_n        = 3'd4;
          emit_valid_n = 1'b1;
          q_data_n     = init_byte(3'd4);
          q_cmd_n      = 1'b0;
        end else begin
          timer_n = timer + TW'(1);
        end
      end

      IDLE: begin
        if (pick_found) begin
          dirty_clr[pick_row] = 1'b1;
          row_n               = pick_row;
          col_n               = 4'd0;
          state_n             = ADDR;
          emit_valid_n        = 1'b1;
          q_data_n            = row_base(pick_row);
          q_cmd_n             = 1'b0;
        end
      end

      ADDR: begin
        if (sent) begin
          state_n  = DATA;
          q_data_n = shadow[row][4'd0];
          q_cmd_n  = 1'b1;
        end
      end

      DATA: begin
        if (sent) begin
          if (col == 4'd15) begin
            state_n      = IDLE;
            emit_valid_n = 1'b0;
            rr_n         = row + 2'd1;
          end else begin
            col_n    = col_inc;
            q_data_n = shadow[row][col_inc];
          end
        end
      end

      default: begin
        state_n      = PWRUP;
        emit_valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PWRUP;
      timer      <= '0;
      idx        <= 3'd0;
      row        <= 2'd0;
      col        <= 4'd0;
      rr         <= 2'd0;
      emit_valid <= 1'b0;
      q_data     <= 8'h00;
      q_cmd      <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      idx        <= idx_n;
      row        <= row_n;
      col        <= col_n;
      rr         <= rr_n;
      emit_valid <= emit_valid_n;
      q_data     <= q_data_n;
      q_cmd      <= q_cmd_n;
      init_done  <= init_done_n;
    end
  end

  // Host writes and refresh are applied after the IDLE clear so a set always wins.
  assign dirty_set = host_we ? (4'b0001 << host_row) : 4'b0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dirty <= 4'b1111;
    end else begin
      dirty <= (dirty & ~dirty_clr) | dirty_set | {4{refresh}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 16; c++) begin
          shadow[r][c] <= 8'h20;
        end
      end
    end else if (host_we) begin
      shadow[host_row][host_col] <= host_char;
    end
  end

endmodule

// File: tb/tb_lcd_12864b_seq.sv
// Directed bench for lcd_12864b_seq: captures every enqueued byte and compares the
// stream against hand-built init/row tables and a small shadow-buffer model.
module tb_lcd_12864b_seq;

  localparam int PW = 10;
  localparam int CW = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       host_we = 1'b0;
  logic [1:0] host_row = 2'd0;
  logic [3:0] host_col = 4'd0;
  logic [7:0] host_char = 8'h00;
  logic       refresh = 1'b0;
  logic       q_full = 1'b0;
  logic [7:0] q_data;
  logic       q_cmd;
  logic       q_wr;
  logic       init_done;
  logic       busy;

  lcd_12864b_seq #(.PWRUP_CYC(PW), .CLR_CYC(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .host_we   (host_we),
    .host_row  (host_row),
    .host_col  (host_col),
    .host_char (host_char),
    .refresh   (refresh),
    .q_full    (q_full),
    .q_data    (q_data),
    .q_cmd     (q_cmd),
    .q_wr      (q_wr),
    .init_done (init_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         gap;
  } init_t;

  typedef struct {
    logic [1:0] row;
    logic [3:0] col;
    logic [7:0] ch;
    logic [7:0] exp_addr;
  } vec_t;

  int         cyc = 0;
  int         viol = 0;
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc_rel = 0;
  logic [8:0] cap_q[$];
  int         stamp_q[$];
  logic [7:0] model [4][16];
  logic [7:0] addr_tab [4];
  init_t      init_tab [5];
  vec_t       vecs [4];

  always @(posedge clk) cyc <= cyc + 1;

  // Byte capture and full-flag protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (q_wr === 1'b1 && q_full === 1'b1) viol++;
    if (rst_n && q_wr === 1'b1) begin
      cap_q.push_back({q_cmd, q_data});
      stamp_q.push_back(cyc);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] r, input logic [3:0] c,
                               input logic [7:0] ch, input logic refr);
    host_we   = we;
    host_row  = r;
    host_col  = c;
    host_char = ch;
    refresh   = refr;
    @(posedge clk);
    #1;
    host_we = 1'b0;
    refresh = 1'b0;
  endtask

  task automatic waitBytes(input int n, input int budget);
    int k = 0;
    while (cap_q.size() < n && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (cap_q.size() < n) checkOutput("byte timeout", cap_q.size(), n);
  endtask

  task automatic expectRowAt(input logic [1:0] r, input logic [7:0] exp_addr);
    logic [8:0] b;
    waitBytes(17, 2000);
    if (cap_q.size() >= 17) begin
      b = cap_q.pop_front();
      void'(stamp_q.pop_front());
      checkOutput($sformatf("row%0d addr", r), b, {1'b0, exp_addr});
      for (int c = 0; c < 16; c++) begin
        b = cap_q.pop_front();
        void'(stamp_q.pop_front());
        checkOutput($sformatf("row%0d col%0d", r, c), b, {1'b1, model[r][c]});
      end
    end
  endtask

  task automatic expectRow(input logic [1:0] r);
    expectRowAt(r, addr_tab[r]);
  endtask

  task automatic expectQuiet();
    repeat (5) @(posedge clk);
    #1;
    checkOutput("extra bytes", cap_q.size(), 0);
    checkOutput("busy idle", busy, 1'b0);
    cap_q.delete();
    stamp_q.delete();
  endtask

  task automatic checkInit();
    logic [8:0] b;
    int         s;
    int         prev;
    prev = cyc_rel;
    waitBytes(5, 200);
    if (cap_q.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        b = cap_q.pop_front();
        s = stamp_q.pop_front();
        checkOutput($sformatf("init byte %0d", i), b, {1'b0, init_tab[i].data});
        checkOutput($sformatf("init gap %0d", i), s - prev, init_tab[i].gap);
        prev = s;
      end
    end
  endtask

  task automatic resetModel();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 16; c++)
        model[r][c] = 8'h20;
  endtask

  task automatic checkResetOutputs();
    checkOutput("reset q_wr", q_wr, 1'b0);
    checkOutput("reset q_data", q_data, 8'h00);
    checkOutput("reset q_cmd", q_cmd, 1'b0);
    checkOutput("reset init_done", init_done, 1'b0);
    checkOutput("reset busy", busy, 1'b1);
  endtask

  task automatic releaseAndInit();
    @(posedge clk);
    #1;
    cap_q.delete();
    stamp_q.delete();
    cyc_rel = cyc;
    rst_n   = 1'b1;
    checkInit();
    for (int r = 0; r < 4; r++) expectRow(2'(r));
    checkOutput("init_done high", init_done, 1'b1);
    expectQuiet();
  endtask

  initial begin
    addr_tab    = '{8'h80, 8'h90, 8'h88, 8'h98};
    init_tab[0] = '{8'h30, PW};
    init_tab[1] = '{8'h30, 1};
    init_tab[2] = '{8'h0C, 1};
    init_tab[3] = '{8'h01, 1};
    init_tab[4] = '{8'h06, CW + 1};
    vecs[0]     = '{2'd2, 4'd3,  8'h41, 8'h88};
    vecs[1]     = '{2'd0, 4'd0,  8'h31, 8'h80};
    vecs[2]     = '{2'd3, 4'd15, 8'h7E, 8'h98};
    vecs[3]     = '{2'd1, 4'd7,  8'h55, 8'h90};
    resetModel();

    // Reset state, power-up delay, init list with clear wait, initial full redraw.
    #2;
    checkResetOutputs();
    repeat (3) @(posedge clk);
    releaseAndInit();

    // Single-character writes from idle: only the touched row is redrawn.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, vecs[i].row, vecs[i].col, vecs[i].ch, 1'b0);
      model[vecs[i].row][vecs[i].col] = vecs[i].ch;
      expectRowAt(vecs[i].row, vecs[i].exp_addr);
      expectQuiet();
    end

    // Back-pressure toggling every cycle during a row.
    applyStimulus(1'b1, 2'd0, 4'd9, 8'h33, 1'b0);
    model[0][9] = 8'h33;
    for (int k = 0; k < 60; k++) begin
      q_full = ~q_full;
      @(posedge clk);
      #1;
    end
    q_full = 1'b0;
    expectRow(2'd0);
    expectQuiet();

    // Rows 1 and 3 dirty with rr=2: row 3 must precede row 1.
    applyStimulus(1'b1, 2'd1, 4'd0, 8'h61, 1'b0);
    model[1][0] = 8'h61;
    waitBytes(1, 100);
    q_full = 1'b1;
    applyStimulus(1'b1, 2'd1, 4'd0, 8'h62, 1'b0);
    applyStimulus(1'b1, 2'd3, 4'd1, 8'h63, 1'b0);
    model[3][1] = 8'h63;
    q_full = 1'b0;
    expectRow(2'd1);
    model[1][0] = 8'h62;
    expectRow(2'd3);
    expectRow(2'd1);
    expectQuiet();

    // Write behind the stream position: row completes unpatched, then a full redraw.
    applyStimulus(1'b1, 2'd1, 4'd8, 8'h70, 1'b0);
    model[1][8] = 8'h70;
    waitBytes(9, 200);
    applyStimulus(1'b1, 2'd1, 4'd2, 8'h5A, 1'b0);
    expectRow(2'd1);
    model[1][2] = 8'h5A;
    expectRow(2'd1);
    expectQuiet();

    // Refresh after a row-1 redraw scans from rr=2.
    applyStimulus(1'b0, 2'd0, 4'd0, 8'h00, 1'b1);
    expectRow(2'd2);
    expectRow(2'd3);
    expectRow(2'd0);
    expectRow(2'd1);
    expectQuiet();

    // Reset in the middle of a data row.
    applyStimulus(1'b1, 2'd2, 4'd5, 8'h44, 1'b0);
    waitBytes(5, 100);
    rst_n = 1'b0;
    #1;
    checkResetOutputs();
    resetModel();
    releaseAndInit();

    checkOutput("q_wr while q_full", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
